mac_tx_header_insert: RTL



---
 rtl/mac_tx_header_insert.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_header_insert.sv
// rtl/mac_tx_header_insert.sv - Ethernet header insertion with payload length limit (optional MAC_TX_VLAN_EN)
module mac_tx_header_insert #(
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_01_02,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [47:0] hdr_dst_mac,
  input  logic [15:0] hdr_eth_type,
`ifdef MAC_TX_VLAN_EN
  input  logic [15:0] hdr_vlan_tci,
`endif
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  input  logic        mac_tready_in,
  output logic        mac_tlast_out,
  output logic        frame_done,
  output logic        trunc_err
);

`ifdef MAC_TX_VLAN_EN
  localparam logic [4:0] HDR_LAST = 5'd17;
`else
  localparam logic [4:0] HDR_LAST = 5'd13;
`endif
  localparam logic [10:0] PAY_LAST = 11'(MAX_PAYLOAD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_alive;
  logic [47:0] r_dst;
  logic [15:0] r_type;
`ifdef MAC_TX_VLAN_EN
  logic [15:0] r_tci;
`endif
  logic [4:0]  r_hdr_cnt;
  logic [10:0] r_pay_cnt;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_frame_done;
  logic        r_trunc;

  logic        w_out_free;
  logic [7:0]  w_hdr_byte;
  logic        w_hdr_ready;
  logic        w_s_tready;
  logic        w_hdr_take;
  logic        w_pay_take;
  logic        w_ld;
  logic [7:0]  w_ld_data;
  logic        w_ld_last;
  logic        w_trunc;
  logic        w_pay_at_max;

  assign w_out_free   = !r_tvalid || mac_tready_in;
  assign w_pay_at_max = (r_pay_cnt == PAY_LAST);

  // Select the header byte addressed by the header counter
  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_hdr_cnt)
      5'd0:  w_hdr_byte = r_dst[47:40];
      5'd1:  w_hdr_byte = r_dst[39:32];
      5'd2:  w_hdr_byte = r_dst[31:24];
      5'd3:  w_hdr_byte = r_dst[23:16];
      5'd4:  w_hdr_byte = r_dst[15:8];
      5'd5:  w_hdr_byte = r_dst[7:0];
      5'd6:  w_hdr_byte = SRC_MAC[47:40];
      5'd7:  w_hdr_byte = SRC_MAC[39:32];
      5'd8:  w_hdr_byte = SRC_MAC[31:24];
      5'd9:  w_hdr_byte = SRC_MAC[23:16];
      5'd10: w_hdr_byte = SRC_MAC[15:8];
      5'd11: w_hdr_byte = SRC_MAC[7:0];
`ifdef MAC_TX_VLAN_EN
      5'd12: w_hdr_byte = 8'h81;
      5'd13: w_hdr_byte = 8'h00;
      5'd14: w_hdr_byte = r_tci[15:8];
      5'd15: w_hdr_byte = r_tci[7:0];
      5'd16: w_hdr_byte = r_type[15:8];
      5'd17: w_hdr_byte = r_type[7:0];
`else
      5'd12: w_hdr_byte = r_type[15:8];
      5'd13: w_hdr_byte = r_type[7:0];
`endif
      default: w_hdr_byte = 8'h00;
    endcase
  end

  // Next-state and handshake/output-load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_ready = 1'b0;
    w_s_tready  = 1'b0;
    w_hdr_take  = 1'b0;
    w_pay_take  = 1'b0;
    w_ld        = 1'b0;
    w_ld_data   = 8'h00;
    w_ld_last   = 1'b0;
    w_trunc     = 1'b0;
    case (r_state)
      IDLE: begin
        // r_alive keeps hdr_ready low until the first clock after reset release
        w_hdr_ready = r_alive;
        if (hdr_valid && r_alive) begin
          w_hdr_take  = 1'b1;
          w_state_nxt = HEADER;
        end
      end
      HEADER: begin
        if (w_out_free) begin
          w_ld      = 1'b1;
          w_ld_data = w_hdr_byte;
          if (r_hdr_cnt == HDR_LAST) begin
            w_state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        w_s_tready = w_out_free;
        if (s_tvalid && w_out_free) begin
          w_ld       = 1'b1;
          w_pay_take = 1'b1;
          w_ld_data  = s_tdata;
          w_ld_last  = s_tlast || w_pay_at_max;
          if (s_tlast) begin
            w_state_nxt = IDLE;
          end else if (w_pay_at_max) begin
            w_trunc     = 1'b1;
            w_state_nxt = DROP;
          end
        end
      end
      DROP: begin
        w_s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and reset-release tracking
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  // Descriptor latch and byte counters
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_dst     <= 48'h0;
      r_type    <= 16'h0;
`ifdef MAC_TX_VLAN_EN
      r_tci     <= 16'h0;
`endif
      r_hdr_cnt <= 5'd0;
      r_pay_cnt <= 11'd0;
    end else begin
      if (w_hdr_take) begin
        r_dst     <= hdr_dst_mac;
        r_type    <= hdr_eth_type;
`ifdef MAC_TX_VLAN_EN
        r_tci     <= hdr_vlan_tci;
`endif
        r_hdr_cnt <= 5'd0;
      end else if (r_state == HEADER && w_ld) begin
        r_hdr_cnt <= r_hdr_cnt + 5'd1;
        if (r_hdr_cnt == HDR_LAST) begin
          r_pay_cnt <= 11'd0;
        end
      end
      if (w_pay_take) begin
        r_pay_cnt <= r_pay_cnt + 11'd1;
      end
    end
  end

  // Single output register stage; holds while downstream stalls
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_ld) begin
      r_tdata  <= w_ld_data;
      r_tvalid <= 1'b1;
      r_tlast  <= w_ld_last;
    end else if (w_out_free) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // One-cycle status pulses
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_frame_done <= 1'b0;
      r_trunc      <= 1'b0;
    end else begin
      r_frame_done <= r_tvalid && mac_tready_in && r_tlast;
      r_trunc      <= w_trunc;
    end
  end

  assign hdr_ready      = w_hdr_ready;
  assign s_tready       = w_s_tready;
  assign mac_tdata_out  = r_tdata;
  assign mac_tvalid_out = r_tvalid;
  assign mac_tlast_out  = r_tlast;
  assign frame_done     = r_frame_done;
  assign trunc_err      = r_trunc;

endmodule
